skin_mask_centroid: RTL and testbench
=====================================

// Module: skin_mask_centroid
// PURPOSE
//  Streaming skin-colour segmenter plus hand-position estimator. Takes one RGB pixel per
//  pix_valid in raster order and classifies it on the red-minus-green chroma difference
//  against a programmable window. Emits a binary mask pixel and accumulates per-frame
//  coordinate sums of masked pixels. Sits between camera capture and the VGA/hex-display
//  path; the sums/centroid drive the hand-position readout.
// PARAMETERS
//  PIX_W     8    bits per colour channel
//  H_ACTIVE  640  pixels per line
//  V_ACTIVE  480  lines per frame
//  THR_W     9    width of thr_lo/thr_hi (signed difference range)
//  SUM_W     32   width of sum_x/sum_y accumulators
//  CNT_W     20   width of mask_count
// PORTS
//  clock       in   1      sole clock, all logic rising-edge
//  reset_n     in   1      asynchronous active-low reset
//  pix_valid   in   1      pix_r/g/b valid this cycle; no backpressure
//  pix_r       in   PIX_W  red
//  pix_g       in   PIX_W  green
//  pix_b       in   PIX_W  blue (carried, unused by classifier)
//  thr_lo      in   THR_W  lower window bound, signed, exclusive
//  thr_hi      in   THR_W  upper window bound, signed, exclusive
//  mask_valid  out  1      mask_out valid
//  mask_out    out  PIX_W  all-ones = skin, zero = background
//  frame_done  out  1      one-cycle pulse, frame results updated
//  sum_x       out  SUM_W  sum of column indices of masked pixels, last frame
//  sum_y       out  SUM_W  sum of row indices of masked pixels, last frame
//  mask_count  out  CNT_W  number of masked pixels, last frame
//  cent_x      out  10     centroid column (see CONFIGURATION)
//  cent_y      out  10     centroid row
//  cent_valid  out  1      one-cycle pulse, cent_x/cent_y updated
// BEHAVIOUR
//  - Reset: all outputs, counters, accumulators, divider state = 0; col=row=0.
//  - Stage 1 (reg): diff = $signed({1'b0,R}) - $signed({1'b0,G}), THR_W bits; col/row tagged.
//  - Stage 2 (reg): skin = (diff > thr_lo) && (diff < thr_hi), signed; mask_out = skin ? all-ones : 0.
//  - Latency pix_valid -> mask_valid = 2 cycles; mask_valid is pix_valid delayed 2.
//  - Negative diff never wraps: R<G gives negative diff, masked only if window allows.
//  - thr_lo/thr_hi sampled when pixel (0,0) enters stage 1; held constant for the frame.
//  - thr_lo >= thr_hi: no pixel masked; no error flag.
//  - col increments per accepted pixel; at H_ACTIVE-1 wraps to 0, row++.
//  - At row V_ACTIVE-1, col H_ACTIVE-1: row wraps to 0; frame ends.
//  - Stage 2 accumulates on skin: acc_x += col, acc_y += row, acc_n += 1.
//  - Cycle after last pixel leaves stage 2: sum_x/sum_y/mask_count <= acc + final pixel;
//    frame_done=1 for one cycle; acc cleared same edge. Outputs hold until next frame_done.
//  - Pixel (0,0) of next frame may arrive back-to-back; accumulates into cleared acc.
//  - Gaps in pix_valid stall counters/pipeline advance only; no timeout.
//  - reset_n low mid-frame: partial frame discarded, no frame_done, restart at (0,0).
// CONFIGURATION
//  CENTROID_DIV_EN defined: two parallel restoring dividers (SUM_W-cycle, one quotient bit
//    per cycle). FSM IDLE -> DIV (on frame_done) -> DONE -> IDLE. DIV takes SUM_W cycles.
//    DONE: cent_x = sum_x/mask_count, cent_y = sum_y/mask_count (truncated), cent_valid=1.
//    mask_count==0: skip DIV, cent_x=cent_y=0, cent_valid 1 cycle after frame_done.
//    frame_done while in DIV: abort, restart with new sums; no cent_valid for aborted frame.
//  CENTROID_DIV_EN undefined: no divider; cent_x=cent_y=0 constant; cent_valid = frame_done.
// TESTING (bench uses H_ACTIVE=4, V_ACTIVE=2, thr_lo=10, thr_hi=74)
//  R=60,G=20 single pixel -> mask_valid 2 cycles later, mask_out=8'hFF.
//  R=20,G=60 (diff -40) -> mask_out=0; diffs 10/11/73/74 -> 0/FF/FF/0.
//  Full frame of R=60,G=20 -> frame_done, mask_count=8, sum_x=12, sum_y=4;
//    with CENTROID_DIV_EN cent_x=1, cent_y=0, cent_valid SUM_W+1 cycles after frame_done.
//  All-background frame -> mask_count=0, sums 0, cent_x=cent_y=0, cent_valid pulses.
//  reset_n low after pixel 5, then full skin frame -> no frame_done before reset, then counts 8/12/4.
//  thr_lo changed mid-frame -> classification unchanged until next pixel (0,0).

Source files
------------

// File: rtl/skin_mask_centroid.sv
// Streaming skin-colour segmenter: R-G chroma window classifier, per-frame masked-pixel sums.
// Optional centroid dividers are built when CENTROID_DIV_EN is defined.
module skin_mask_centroid #(
    parameter int PIX_W    = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int THR_W    = 9,
    parameter int SUM_W    = 32,
    parameter int CNT_W    = 20
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_r,
    input  logic [PIX_W-1:0]        pix_g,
    input  logic [PIX_W-1:0]        pix_b,
    input  logic [THR_W-1:0]        thr_lo,
    input  logic [THR_W-1:0]        thr_hi,
    output logic                    mask_valid,
    output logic [PIX_W-1:0]        mask_out,
    output logic                    frame_done,
    output logic [SUM_W-1:0]        sum_x,
    output logic [SUM_W-1:0]        sum_y,
    output logic [CNT_W-1:0]        mask_count,
    output logic [9:0]              cent_x,
    output logic [9:0]              cent_y,
    output logic                    cent_valid
);

    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    logic [COL_W-1:0]        col_q, s1_col_q;
    logic [ROW_W-1:0]        row_q, s1_row_q;
    logic                    s1_valid_q, s1_last_q;
    logic signed [THR_W-1:0] s1_diff_q, thr_lo_q, thr_hi_q, diff_d;
    logic                    last_col_d, last_d, skin_d;
    logic [SUM_W-1:0]        acc_x_q, acc_y_q, acc_x_d, acc_y_d, sum_x_q, sum_y_q;
    logic [CNT_W-1:0]        acc_n_q, acc_n_d, mask_count_q;
    logic                    mask_valid_q, frame_done_q;
    logic [PIX_W-1:0]        mask_q;
    logic                    pix_b_unused;

    // Blue rides along with the pixel but plays no part in the chroma decision.
    assign pix_b_unused = ^pix_b;

    assign diff_d     = THR_W'({1'b0, pix_r}) - THR_W'({1'b0, pix_g});
    assign last_col_d = (col_q == COL_W'(H_ACTIVE - 1));
    assign last_d     = last_col_d && (row_q == ROW_W'(V_ACTIVE - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pix_valid) begin
            if (last_col_d) begin
                col_q <= '0;
                row_q <= last_d ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Thresholds are latched with pixel (0,0) so a frame is classified with one window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_diff_q  <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            thr_lo_q   <= '0;
            thr_hi_q   <= '0;
        end else begin
            s1_valid_q <= pix_valid;
            if (pix_valid) begin
                s1_diff_q <= diff_d;
                s1_col_q  <= col_q;
                s1_row_q  <= row_q;
                s1_last_q <= last_d;
                if (col_q == '0 && row_q == '0) begin
                    thr_lo_q <= thr_lo;
                    thr_hi_q <= thr_hi;
                end
            end
        end
    end

    always_comb begin
        skin_d  = s1_valid_q && (s1_diff_q > thr_lo_q) && (s1_diff_q < thr_hi_q);
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        acc_n_d = acc_n_q;
        if (skin_d) begin
            acc_x_d = acc_x_q + SUM_W'(s1_col_q);
            acc_y_d = acc_y_q + SUM_W'(s1_row_q);
            acc_n_d = acc_n_q + CNT_W'(1);
        end
    end

    // The last pixel's contribution goes straight into the published sums; acc restarts at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_valid_q <= 1'b0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            acc_n_q      <= '0;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            mask_count_q <= '0;
        end else begin
            mask_valid_q <= s1_valid_q;
            mask_q       <= skin_d ? '1 : '0;
            frame_done_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q && s1_last_q) begin
                sum_x_q      <= acc_x_d;
                sum_y_q      <= acc_y_d;
                mask_count_q <= acc_n_d;
                acc_x_q      <= '0;
                acc_y_q      <= '0;
                acc_n_q      <= '0;
            end else begin
                acc_x_q <= acc_x_d;
                acc_y_q <= acc_y_d;
                acc_n_q <= acc_n_d;
            end
        end
    end

    assign mask_valid = mask_valid_q;
    assign mask_out   = mask_q;
    assign frame_done = frame_done_q;
    assign sum_x      = sum_x_q;
    assign sum_y      = sum_y_q;
    assign mask_count = mask_count_q;

`ifdef CENTROID_DIV_EN
    localparam int STEP_W = $clog2(SUM_W);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q;
    logic [STEP_W-1:0] step_q;
    logic [SUM_W-1:0]  divisor_q, quo_x_q, quo_y_q, rem_x_q, rem_y_q;
    logic [SUM_W-1:0]  quo_x_d, quo_y_d, rem_x_d, rem_y_d, shift_x, shift_y;
    logic [9:0]        cent_x_q, cent_y_q;
    logic              rem_msb_unused;

    // Remainder stays below the divisor (< 2^CNT_W), so its top bit never carries data.
    assign rem_msb_unused = rem_x_q[SUM_W-1] ^ rem_y_q[SUM_W-1];

    always_comb begin
        shift_x = {rem_x_q[SUM_W-2:0], quo_x_q[SUM_W-1]};
        shift_y = {rem_y_q[SUM_W-2:0], quo_y_q[SUM_W-1]};
        rem_x_d = (shift_x >= divisor_q) ? shift_x - divisor_q : shift_x;
        rem_y_d = (shift_y >= divisor_q) ? shift_y - divisor_q : shift_y;
        quo_x_d = {quo_x_q[SUM_W-2:0], shift_x >= divisor_q};
        quo_y_d = {quo_y_q[SUM_W-2:0], shift_y >= divisor_q};
    end

    // A new frame_done always wins, so an unfinished division is simply restarted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            divisor_q <= '0;
            quo_x_q   <= '0;
            quo_y_q   <= '0;
            rem_x_q   <= '0;
            rem_y_q   <= '0;
            cent_x_q  <= '0;
            cent_y_q  <= '0;
        end else if (frame_done_q) begin
            if (mask_count_q == '0) begin
                state_q  <= ST_DONE;
                cent_x_q <= '0;
                cent_y_q <= '0;
            end else begin
                state_q   <= ST_DIV;
                step_q    <= '0;
                divisor_q <= SUM_W'(mask_count_q);
                quo_x_q   <= sum_x_q;
                quo_y_q   <= sum_y_q;
                rem_x_q   <= '0;
                rem_y_q   <= '0;
            end
        end else begin
            case (state_q)
                ST_DIV: begin
                    quo_x_q <= quo_x_d;
                    quo_y_q <= quo_y_d;
                    rem_x_q <= rem_x_d;
                    rem_y_q <= rem_y_d;
                    step_q  <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(SUM_W - 1)) begin
                        state_q  <= ST_DONE;
                        cent_x_q <= quo_x_d[9:0];
                        cent_y_q <= quo_y_d[9:0];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cent_x     = cent_x_q;
    assign cent_y     = cent_y_q;
    assign cent_valid = (state_q == ST_DONE);
`else
    assign cent_x     = '0;
    assign cent_y     = '0;
    assign cent_valid = frame_done_q;
`endif

endmodule

// File: tb/tb_skin_mask_centroid.sv
// Randomized scoreboard bench for skin_mask_centroid on a 4x2 frame.
// Expected masks, frame sums and centroids come from a plain-arithmetic pixel model.
module tb_skin_mask_centroid;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int SUM_W = 32;
    localparam int CNT_W = 20;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             pix_valid = 1'b0;
    logic [7:0]       pix_r = '0, pix_g = '0, pix_b = '0;
    logic [8:0]       thr_lo = '0, thr_hi = '0;
    logic             mask_valid, frame_done, cent_valid;
    logic [7:0]       mask_out;
    logic [SUM_W-1:0] sum_x, sum_y;
    logic [CNT_W-1:0] mask_count;
    logic [9:0]       cent_x, cent_y;

    skin_mask_centroid #(
        .PIX_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .THR_W(9), .SUM_W(SUM_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .thr_lo(thr_lo), .thr_hi(thr_hi),
        .mask_valid(mask_valid), .mask_out(mask_out), .frame_done(frame_done),
        .sum_x(sum_x), .sum_y(sum_y), .mask_count(mask_count),
        .cent_x(cent_x), .cent_y(cent_y), .cent_valid(cent_valid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [7:0] mask; int cyc; } maskExp_t;
    typedef struct { longint sx; longint sy; longint n; } frameExp_t;

    maskExp_t  maskQ[$];
    frameExp_t frameQ[$];
    int        total = 0, bad = 0;
    int        frameSeen = 0, frameExpected = 0;
    int        thrLoV = 10, thrHiV = 74;
    int        mIdx = 0, mLo = 0, mHi = 0;
    longint    mSx = 0, mSy = 0, mN = 0;
    bit        centPend = 1'b0;
    int        centDue = 0;
    longint    centExpX = 0, centExpY = 0;

    task automatic checkOutput(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic setThr(int lo, int hi);
        thrLoV = lo;
        thrHiV = hi;
        thr_lo = 9'(lo);
        thr_hi = 9'(hi);
    endtask

    // Reference: raster index gives column/row; window captured at index 0 of each frame.
    task automatic modelPixel(int r, int g);
        int  diff;
        bit  skin;
        maskExp_t  me;
        frameExp_t fe;
        if (mIdx == 0) begin
            mLo = thrLoV;
            mHi = thrHiV;
        end
        diff = r - g;
        skin = (diff > mLo) && (diff < mHi);
        me.mask = skin ? 8'hFF : 8'h00;
        me.cyc  = cyc;
        maskQ.push_back(me);
        if (skin) begin
            mSx += mIdx % H;
            mSy += mIdx / H;
            mN++;
        end
        mIdx++;
        if (mIdx == H * V) begin
            fe.sx = mSx;
            fe.sy = mSy;
            fe.n  = mN;
            frameQ.push_back(fe);
            frameExpected++;
            mIdx = 0;
            mSx = 0;
            mSy = 0;
            mN = 0;
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clock);
            #1 pix_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(int r, int g, int gap);
        idle(gap);
        @(posedge clock);
        #1;
        pix_r = 8'(r);
        pix_g = 8'(g);
        pix_b = 8'($urandom);
        pix_valid = 1'b1;
        modelPixel(r, g);
    endtask

    task automatic skinFrame();
        for (int i = 0; i < H * V; i++) applyStimulus(60, 20, 0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_mask_valid", mask_valid, 0);
        checkOutput("rst_mask_out", mask_out, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_sum_x", sum_x, 0);
        checkOutput("rst_sum_y", sum_y, 0);
        checkOutput("rst_mask_count", mask_count, 0);
        checkOutput("rst_cent_x", cent_x, 0);
        checkOutput("rst_cent_y", cent_y, 0);
        checkOutput("rst_cent_valid", cent_valid, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clock) begin
        maskExp_t  me;
        frameExp_t fe;
        if (mask_valid) begin
            if (maskQ.size() == 0) begin
                checkOutput("unexpected_mask_valid", 1, 0);
            end else begin
                me = maskQ.pop_front();
                checkOutput("mask_out", mask_out, me.mask);
                checkOutput("mask_latency", cyc - me.cyc, 2);
            end
        end
`ifdef CENTROID_DIV_EN
        if (cent_valid) begin
            if (!centPend) begin
                checkOutput("unexpected_cent_valid", 1, 0);
            end else begin
                checkOutput("cent_latency", cyc, centDue);
                checkOutput("cent_x", cent_x, centExpX);
                checkOutput("cent_y", cent_y, centExpY);
                centPend = 1'b0;
            end
        end else if (centPend && cyc >= centDue) begin
            checkOutput("cent_valid_timeout", cyc, centDue);
            centPend = 1'b0;
        end
`else
        if (cent_valid && !frame_done) checkOutput("cent_valid_without_frame_done", 1, 0);
`endif
        if (frame_done) begin
            frameSeen++;
            if (frameQ.size() == 0) begin
                checkOutput("unexpected_frame_done", 1, 0);
            end else begin
                fe = frameQ.pop_front();
                checkOutput("sum_x", sum_x, fe.sx);
                checkOutput("sum_y", sum_y, fe.sy);
                checkOutput("mask_count", mask_count, fe.n);
`ifdef CENTROID_DIV_EN
                centPend = 1'b1;
                centExpX = (fe.n == 0) ? 0 : (fe.sx / fe.n) % 1024;
                centExpY = (fe.n == 0) ? 0 : (fe.sy / fe.n) % 1024;
                centDue  = cyc + ((fe.n == 0) ? 1 : SUM_W + 1);
`else
                checkOutput("cent_valid_with_frame_done", cent_valid, 1);
                checkOutput("cent_x_const", cent_x, 0);
                checkOutput("cent_y_const", cent_y, 0);
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lo, hi, gapMax;
        setThr(10, 74);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetState();
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Single pixel, then window edges: diffs -40, 10, 11, 73, 74.
        applyStimulus(60, 20, 0);
        idle(4);
        applyStimulus(20, 60, 0);
        applyStimulus(30, 20, 1);
        applyStimulus(31, 20, 0);
        applyStimulus(93, 20, 2);
        applyStimulus(94, 20, 0);
        applyStimulus(60, 20, 0);
        applyStimulus(60, 20, 0);
        idle(50);

        skinFrame();
        idle(50);
        for (int i = 0; i < H * V; i++) applyStimulus(20, 60, 0);
        idle(50);

        // Window change mid-frame applies only from the next frame's first pixel.
        for (int i = 0; i < H * V; i++) begin
            if (i == 4) setThr(100, 120);
            applyStimulus(60, 20, 0);
        end
        skinFrame();
        setThr(10, 74);
        skinFrame();
        idle(50);

        setThr(74, 10);
        skinFrame();
        idle(40);
        setThr(40, 40);
        skinFrame();
        idle(50);
        setThr(10, 74);

        // Partial frame abandoned by reset, then a clean frame.
        for (int i = 0; i < 5; i++) applyStimulus(60, 20, 0);
        idle(3);
        checkOutput("no_frame_done_before_reset", frameSeen, frameExpected);
        reset_n = 1'b0;
        mIdx = 0;
        mSx = 0;
        mSy = 0;
        mN = 0;
        @(negedge clock);
        checkResetState();
        @(posedge clock);
        #1 reset_n = 1'b1;
        skinFrame();
        idle(50);

        for (int f = 0; f < 10; f++) begin
            lo = $urandom_range(0, 100) - 60;
            hi = lo + $urandom_range(0, 130) - 10;
            setThr(lo, hi);
            gapMax = (f % 3 == 0) ? 0 : 2;
            for (int p = 0; p < H * V; p++) begin
                if (p == 4 && ($urandom_range(0, 1) == 1))
                    setThr($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100);
                applyStimulus($urandom_range(0, 255), $urandom_range(0, 255),
                              $urandom_range(0, gapMax));
            end
            if (f % 4 == 3) idle(45);
        end
        idle(1);

        for (int i = 0; i < 100; i++) begin
            if (maskQ.size() == 0 && frameQ.size() == 0 && !centPend) break;
            @(posedge clock);
        end
        @(negedge clock);
        checkOutput("mask_queue_drained", maskQ.size(), 0);
        checkOutput("frame_queue_drained", frameQ.size(), 0);
        checkOutput("cent_not_pending", centPend, 0);
        checkOutput("frames_seen", frameSeen, frameExpected);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
